// File: rtl/dot_product_scheduler.sv
// Schedules the shared dot-product engine over every classifier neuron.
// It streams row addresses, captures each score and tracks a signed argmax.
`timescale 1ns/1ps

module dot_product_scheduler #(
  parameter int NEURONS = 10,
  parameter int ROWS    = 28,
  parameter int VAL_W   = 26,
  parameter int TIMEOUT = 512
) (
  input  logic             clk,
  input  logic             GlobalReset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [3:0]       neuron_idx,
  output logic             eng_start,
  output logic             row_valid,
  output logic [4:0]       row_addr,
  input  logic             eng_done,
  input  logic [VAL_W-1:0] eng_value,
  output logic             res_we,
  output logic [3:0]       res_addr,
  output logic [VAL_W-1:0] res_data,
  output logic [3:0]       class_idx,
  output logic [VAL_W-1:0] class_score
);

  localparam int          CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [3:0]  LAST_N   = 4'(NEURONS - 1);
  localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_STREAM,
    S_WAIT,
    S_CAPTURE,
    S_FIN
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         neuron_q;
  logic [4:0]         row_q;
  logic [CNT_W-1:0]   wait_q;
  logic [VAL_W-1:0]   val_q;
  logic [3:0]         best_idx_q;
  logic [VAL_W-1:0]   best_val_q;
  logic               error_q;

  logic               accept;
  logic               timeout_hit;
  logic               take_best;

  assign accept      = (state_q == S_IDLE) && start;
  assign timeout_hit = (state_q == S_WAIT) && !eng_done && (wait_q == LAST_WAIT);
  // Neuron 0 seeds the argmax; later neurons must be strictly greater so ties keep the lower index.
  assign take_best   = (neuron_q == 4'd0) || ($signed(val_q) > $signed(best_val_q));

  // NOTE: every combinational output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    eng_start = 1'b0;
    row_valid = 1'b0;
    res_we    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_START;
      end
      S_START: begin
        busy      = 1'b1;
        eng_start = 1'b1;
        state_d   = S_STREAM;
      end
      S_STREAM: begin
        busy      = 1'b1;
        row_valid = 1'b1;
        if (row_q == LAST_ROW) state_d = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (eng_done)         state_d = S_CAPTURE;
        else if (timeout_hit) state_d = S_FIN;
      end
      S_CAPTURE: begin
        busy    = 1'b1;
        res_we  = 1'b1;
        state_d = (neuron_q == LAST_N) ? S_FIN : S_START;
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Row counter runs only while streaming; it stops at ROWS-1 because STREAM exits there.
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      row_q  <= '0;
      wait_q <= '0;
    end else begin
      if (state_q == S_START) begin
        row_q <= '0;
      end else if (state_q == S_STREAM && row_q != LAST_ROW) begin
        row_q <= row_q + 5'd1;
      end
      if (state_q == S_WAIT) begin
        wait_q <= wait_q + 1'b1;
      end else begin
        wait_q <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      neuron_q <= '0;
      val_q    <= '0;
    end else begin
      if (accept) begin
        neuron_q <= '0;
      end else if (state_q == S_CAPTURE && neuron_q != LAST_N) begin
        neuron_q <= neuron_q + 4'd1;
      end
      if (state_q == S_WAIT && eng_done) begin
        val_q <= eng_value;
      end
    end
  end

  // The argmax and error flag survive FIN and are cleared only by the next accepted start.
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      best_idx_q <= '0;
      best_val_q <= '0;
      error_q    <= 1'b0;
    end else begin
      if (accept) begin
        best_idx_q <= '0;
        best_val_q <= '0;
        error_q    <= 1'b0;
      end else begin
        if (state_q == S_CAPTURE && take_best) begin
          best_idx_q <= neuron_q;
          best_val_q <= val_q;
        end
        if (timeout_hit) begin
          error_q <= 1'b1;
        end
      end
    end
  end

  assign neuron_idx  = neuron_q;
  assign row_addr    = row_valid ? row_q : 5'd0;
  assign res_addr    = neuron_q;
  assign res_data    = val_q;
  assign class_idx   = best_idx_q;
  assign class_score = best_val_q;
  assign error       = error_q;

endmodule

// File: tb/tb_dot_product_scheduler.sv
// Directed bench for dot_product_scheduler: an inline engine model answers each
// neuron with a fixed score; expected argmax values are written by hand.
`timescale 1ns/1ps

module tb_dot_product_scheduler;

  localparam int NEURONS  = 10;
  localparam int ROWS     = 28;
  localparam int VAL_W    = 26;
  localparam int TIMEOUT  = 512;
  localparam int DONE_LAT = 4;
  localparam int BUDGET   = 2000;

  logic             clk = 1'b0;
  logic             GlobalReset;
  logic             start;
  logic             busy;
  logic             done;
  logic             error;
  logic [3:0]       neuron_idx;
  logic             eng_start;
  logic             row_valid;
  logic [4:0]       row_addr;
  logic             eng_done;
  logic [VAL_W-1:0] eng_value;
  logic             res_we;
  logic [3:0]       res_addr;
  logic [VAL_W-1:0] res_data;
  logic [3:0]       class_idx;
  logic [VAL_W-1:0] class_score;

  dot_product_scheduler #(
    .NEURONS(NEURONS), .ROWS(ROWS), .VAL_W(VAL_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .GlobalReset(GlobalReset), .start(start), .busy(busy), .done(done),
    .error(error), .neuron_idx(neuron_idx), .eng_start(eng_start), .row_valid(row_valid),
    .row_addr(row_addr), .eng_done(eng_done), .eng_value(eng_value), .res_we(res_we),
    .res_addr(res_addr), .res_data(res_data), .class_idx(class_idx), .class_score(class_score)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  string scen;

  logic signed [VAL_W-1:0] scores [NEURONS];
  int  miss_neuron;
  int  reset_neuron;
  bit  noise;
  int  exp_class;
  int  exp_score;
  int  exp_error;
  int  exp_we;

  int s_base [NEURONS] = '{-5, 3, 7, 7, 0, 1, 2, -1, 6, 4};
  int s_tie  [NEURONS] = '{5, -33554432, 33554431, 33554431, 5, 0, -1, 33554430, 5, 5};

  task automatic check(input string name, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s %s: observed %0d expected %0d", scen, name, obs, exp);
    end
  endtask

  task automatic check_all_zero();
    check("busy zero",        busy, 0);
    check("done zero",        done, 0);
    check("error zero",       error, 0);
    check("neuron_idx zero",  neuron_idx, 0);
    check("eng_start zero",   eng_start, 0);
    check("row_valid zero",   row_valid, 0);
    check("row_addr zero",    row_addr, 0);
    check("res_we zero",      res_we, 0);
    check("res_addr zero",    res_addr, 0);
    check("res_data zero",    $signed(res_data), 0);
    check("class_idx zero",   class_idx, 0);
    check("class_score zero", $signed(class_score), 0);
  endtask

  task automatic setup(input string name, input int src [NEURONS]);
    scen = name;
    foreach (scores[i]) scores[i] = VAL_W'(src[i]);
    miss_neuron  = -1;
    reset_neuron = -1;
    noise        = 1'b0;
    exp_error    = 0;
    exp_we       = NEURONS;
  endtask

  // Drives one inference cycle by cycle: outputs are sampled on the falling edge,
  // then the engine inputs for the next rising edge are set.
  task automatic run_inference();
    int  next_row = 0;
    int  cur_n = 0;
    int  we_cnt = 0;
    int  estart_cnt = 0;
    int  last_row_cyc = -100;
    int  done_cyc = -100;
    bit  prev_estart = 1'b0;
    bit  finished = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 0; cyc < BUDGET && !finished; cyc++) begin
      @(negedge clk);
      start     = 1'b0;
      eng_done  = 1'b0;
      eng_value = VAL_W'($urandom);
      if (cyc == 0) begin
        check("eng_start at t+1", eng_start, 1);
        check("error cleared by start", error, 0);
      end
      if (reset_neuron >= 0 && cur_n == reset_neuron && cyc == last_row_cyc + 2) begin
        GlobalReset = 1'b1;
        @(negedge clk);
        GlobalReset = 1'b0;
        check_all_zero();
        eng_done  = 1'b1;
        eng_value = VAL_W'(123);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          eng_done = 1'b0;
          check("no res_we after reset", res_we, 0);
          check("no done after reset", done, 0);
          check("idle after reset", busy, 0);
        end
        finished = 1'b1;
      end else begin
        if (!done) check("busy during run", busy, 1);
        if (eng_start) begin
          check("eng_start neuron", neuron_idx, cur_n);
          estart_cnt++;
          next_row = 0;
        end
        if (row_valid) begin
          if (next_row == 0) check("eng_start before row 0", prev_estart, 1);
          check("row_addr", row_addr, next_row);
          check("row neuron_idx", neuron_idx, cur_n);
          next_row++;
          if (next_row == ROWS) last_row_cyc = cyc;
          if (noise && next_row == 11) begin
            eng_done = 1'b1;
            start    = 1'b1;
          end
        end
        if (cyc == last_row_cyc + DONE_LAT && cur_n != miss_neuron) begin
          eng_done  = 1'b1;
          eng_value = scores[cur_n];
          done_cyc  = cyc;
        end
        if (noise && cyc == last_row_cyc + 2) start = 1'b1;
        if (res_we) begin
          check("res_we one cycle after eng_done", cyc, done_cyc + 1);
          check("res_addr", res_addr, cur_n);
          check("res_data", $signed(res_data), scores[cur_n]);
          check("rows per neuron", next_row, ROWS);
          check("eng_start pulses per neuron", estart_cnt, 1);
          estart_cnt = 0;
          we_cnt++;
          cur_n++;
        end
        if (done) begin
          check("busy low with done", busy, 0);
          check("res_we count", we_cnt, exp_we);
          check("class_idx", class_idx, exp_class);
          check("class_score", $signed(class_score), exp_score);
          check("error", error, exp_error);
          if (miss_neuron >= 0) check("timeout latency", cyc, last_row_cyc + TIMEOUT + 1);
          finished = 1'b1;
        end
        prev_estart = eng_start;
      end
    end
    if (!finished) check("run finished within budget", 0, 1);
  endtask

  initial begin
    GlobalReset = 1'b1;
    start       = 1'b0;
    eng_done    = 1'b0;
    eng_value   = '0;
    scen        = "reset";
    repeat (3) @(negedge clk);
    check_all_zero();
    GlobalReset = 1'b0;

    setup("basic", s_base);
    exp_class = 2; exp_score = 7;
    run_inference();

    setup("all_negative", s_base);
    foreach (scores[i]) scores[i] = VAL_W'(-100 + i);
    exp_class = 9; exp_score = -91;
    run_inference();

    setup("timeout", s_base);
    miss_neuron = 3; exp_we = 3; exp_error = 1;
    exp_class = 2; exp_score = 7;
    run_inference();
    @(negedge clk);
    check("error sticky in idle", error, 1);
    check("class_idx holds", class_idx, 2);
    check("class_score holds", $signed(class_score), 7);
    check("idle not busy", busy, 0);

    setup("ignored_inputs", s_base);
    noise = 1'b1;
    exp_class = 2; exp_score = 7;
    run_inference();

    setup("reset_mid_run", s_base);
    reset_neuron = 5;
    run_inference();

    setup("after_reset", s_base);
    exp_class = 2; exp_score = 7;
    run_inference();

    setup("ties_extremes", s_tie);
    exp_class = 2; exp_score = 33554431;
    run_inference();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
